mem_port_arbiter: RTL

- Shares the single unified memory port between instruction fetch and the load/store path (LBU/SB traffic) of the RISC-V core.
- Grants one access at a time. Data accesses have priority, and a starvation guard protects fetch.
- Tracks the in-flight access through a fixed memory latency and routes each response back to its owner.
- Sits between the fetch/LSU logic and the memory model.

---
 rtl/mem_port_arbiter_if.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 92 +++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals of the unified
// memory port arbiter. The slave modport is the arbiter's view; the master
// modport is the view of the requesters and the memory model around it.
// The dbg_* signals expose the arbiter's internal state for checkers.
//
// Handshake: a requester raises req with its address/data and keeps them
// stable until gnt is high in the same cycle; the access is taken in that
// cycle. A req dropped before gnt is simply forgotten. Each accepted access
// gets exactly one rvalid pulse, MEM_LAT cycles after its gnt cycle.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      if_req;
    logic [ADDR_WIDTH-1:0]     if_addr;
    logic                      if_gnt;
    logic                      if_rvalid;
    logic [DATA_WIDTH-1:0]     if_rdata;

    logic                      d_req;
    logic                      d_we;
    logic [DATA_WIDTH/8-1:0]   d_wstrb;
    logic [ADDR_WIDTH-1:0]     d_addr;
    logic [DATA_WIDTH-1:0]     d_wdata;
    logic                      d_gnt;
    logic                      d_rvalid;
    logic [DATA_WIDTH-1:0]     d_rdata;

    logic                      mem_en;
    logic                      mem_we;
    logic [DATA_WIDTH/8-1:0]   mem_wstrb;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [DATA_WIDTH-1:0]     mem_rdata;

    logic                      dbg_busy;
    logic                      dbg_owner;
    logic [2:0]                dbg_lat;
    logic [3:0]                dbg_starve;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_wstrb, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata,
        output dbg_busy, dbg_owner, dbg_lat, dbg_starve
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_wstrb, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata,
        input  dbg_busy, dbg_owner, dbg_lat, dbg_starve
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency memory port between instruction fetch
// and the load/store path. Data has priority; after STARVE_MAX consecutive
// data grants with fetch waiting, fetch is forced through. Grants are
// combinational so an access can start in the cycle its request appears,
// including the response cycle of the previous access.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    typedef enum logic {FETCH = 1'b0, DATA = 1'b1} owner_t;

    localparam int         STRB_W     = DATA_WIDTH / 8;
    localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    owner_t     owner;
    logic       owner_we;     // in-flight data access is a store
    logic [2:0] lat_cnt;
    logic [3:0] starve_cnt;

    logic resp;
    logic window;
    logic fetch_win;
    logic data_win;

    // Response detection, grant window and priority selection.
    always_comb begin
        resp      = !rst && (state == BUSY) && (lat_cnt == 3'd1);
        window    = !rst && ((state == IDLE) || resp);
        fetch_win = window && bus.if_req && ((starve_cnt == STARVE_LIM) || !bus.d_req);
        data_win  = window && bus.d_req && !fetch_win;
    end

    // Memory-side strobes are driven only in a grant cycle, zero otherwise.
    assign bus.if_gnt    = fetch_win;
    assign bus.d_gnt     = data_win;
    assign bus.mem_en    = fetch_win || data_win;
    assign bus.mem_we    = data_win && bus.d_we;
    assign bus.mem_wstrb = (data_win && bus.d_we) ? bus.d_wstrb : {STRB_W{1'b0}};
    assign bus.mem_addr  = fetch_win ? bus.if_addr :
                           data_win  ? bus.d_addr  : {ADDR_WIDTH{1'b0}};
    assign bus.mem_wdata = data_win ? bus.d_wdata : {DATA_WIDTH{1'b0}};

    // Response routing: only the owner sees rvalid/rdata; stores return no data.
    assign bus.if_rvalid = resp && (owner == FETCH);
    assign bus.d_rvalid  = resp && (owner == DATA);
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
    assign bus.d_rdata   = (bus.d_rvalid && !owner_we) ? bus.mem_rdata : {DATA_WIDTH{1'b0}};

    assign bus.dbg_busy   = (state == BUSY);
    assign bus.dbg_owner  = (owner == DATA);
    assign bus.dbg_lat    = lat_cnt;
    assign bus.dbg_starve = starve_cnt;

    // State, ownership, latency tracking and starvation counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= FETCH;
            owner_we   <= 1'b0;
            lat_cnt    <= 3'd0;
            starve_cnt <= 4'd0;
        end else begin
            if (fetch_win || data_win) begin
                state    <= BUSY;
                owner    <= fetch_win ? FETCH : DATA;
                owner_we <= data_win && bus.d_we;
                lat_cnt  <= LAT_INIT;
            end else if (state == BUSY) begin
                lat_cnt <= lat_cnt - 3'd1;
                if (lat_cnt == 3'd1) begin
                    state <= IDLE;
                end
            end

            // Counts data grants that bypassed a waiting fetch.
            if (!bus.if_req || fetch_win) begin
                starve_cnt <= 4'd0;
            end else if (data_win && (starve_cnt != STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
endmodule
